// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter that lets the UDP sender and the ICMP echo responder share one IP header transmitter.
// Per packet: grant, zero-latency payload mux, drain, then an inter-packet gap.
module ip_tx_arbiter #(
    parameter int GAP_CYCLES    = 12,
    parameter int START_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        udp_req,
    input  logic [15:0] udp_length,
    input  logic [31:0] udp_dest_ip,
    input  logic        udp_tx_enable,
    input  logic [7:0]  udp_data,
    output logic        udp_grant,
    input  logic        icmp_req,
    input  logic [15:0] icmp_length,
    input  logic [31:0] icmp_dest_ip,
    input  logic        icmp_tx_enable,
    input  logic [7:0]  icmp_data,
    output logic        icmp_grant,
    output logic        ip_tx_enable,
    output logic [7:0]  ip_data,
    output logic        ip_is_icmp,
    output logic [15:0] ip_length,
    output logic [31:0] ip_destination_ip,
    input  logic        ip_active,
    output logic        busy,
    output logic        timeout_err,
    output logic        length_err
);

    typedef enum logic [2:0] {IDLE, GRANT, SEND, DRAIN, GAP} state_t;

    localparam logic [15:0] TimeoutLast = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] GapLoad     = 16'(GAP_CYCLES - 1);

    state_t      state_q;
    logic        udp_grant_q;
    logic        icmp_grant_q;
    logic        last_icmp_q;
    logic        is_icmp_q;
    logic        timeout_err_q;
    logic        length_err_q;
    logic [15:0] len_q;
    logic [31:0] dest_q;
    logic [15:0] byte_cnt_q;
    logic [15:0] timer_q;
    logic [15:0] gap_q;

    logic win_tx_en;
    logic pick_icmp;

    // The latched is_icmp flag selects the winner, so the loser's bus is never looked at.
    assign win_tx_en = is_icmp_q ? icmp_tx_enable : udp_tx_enable;
    assign pick_icmp = icmp_req && (!udp_req || !last_icmp_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            udp_grant_q   <= 1'b0;
            icmp_grant_q  <= 1'b0;
            last_icmp_q   <= 1'b1;
            is_icmp_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            length_err_q  <= 1'b0;
            len_q         <= 16'd0;
            dest_q        <= 32'd0;
            byte_cnt_q    <= 16'd0;
            timer_q       <= 16'd0;
            gap_q         <= 16'd0;
        end else begin
            timeout_err_q <= 1'b0;
            length_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((udp_req || icmp_req) && !ip_active) begin
                        is_icmp_q    <= pick_icmp;
                        last_icmp_q  <= pick_icmp;
                        len_q        <= pick_icmp ? icmp_length : udp_length;
                        dest_q       <= pick_icmp ? icmp_dest_ip : udp_dest_ip;
                        udp_grant_q  <= !pick_icmp;
                        icmp_grant_q <= pick_icmp;
                        timer_q      <= 16'd0;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (win_tx_en) begin
                        byte_cnt_q <= 16'd1;
                        state_q    <= SEND;
                    end else if (timer_q == TimeoutLast) begin
                        udp_grant_q   <= 1'b0;
                        icmp_grant_q  <= 1'b0;
                        timeout_err_q <= 1'b1;
                        gap_q         <= GapLoad;
                        state_q       <= GAP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                SEND: begin
                    if (win_tx_en) begin
                        if (byte_cnt_q != 16'hFFFF)
                            byte_cnt_q <= byte_cnt_q + 16'd1;
                    end else begin
                        // Mismatched bursts are flagged but passed through untouched.
                        udp_grant_q  <= 1'b0;
                        icmp_grant_q <= 1'b0;
                        length_err_q <= (byte_cnt_q != len_q);
                        state_q      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!ip_active) begin
                        gap_q   <= GapLoad;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == 16'd0)
                        state_q <= IDLE;
                    else
                        gap_q <= gap_q - 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign udp_grant         = udp_grant_q;
    assign icmp_grant        = icmp_grant_q;
    assign ip_tx_enable      = win_tx_en && ((state_q == GRANT) || (state_q == SEND));
    assign ip_data           = is_icmp_q ? icmp_data : udp_data;
    assign ip_is_icmp        = is_icmp_q;
    assign ip_length         = len_q;
    assign ip_destination_ip = dest_q;
    assign busy              = (state_q != IDLE);
    assign timeout_err       = timeout_err_q;
    assign length_err        = length_err_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: single source, gap timing, length error, foreign-source isolation,
// start timeout, asynchronous mid-burst reset and round-robin alternation with a zero-length source.
module tb_ip_tx_arbiter;

    localparam int GAP = 12;
    localparam int TMO = 255;

    logic        clock = 1'b0;
    logic        reset;
    logic        udp_req, udp_tx_enable, udp_grant;
    logic [15:0] udp_length;
    logic [31:0] udp_dest_ip;
    logic [7:0]  udp_data;
    logic        icmp_req, icmp_tx_enable, icmp_grant;
    logic [15:0] icmp_length;
    logic [31:0] icmp_dest_ip;
    logic [7:0]  icmp_data;
    logic        ip_tx_enable, ip_is_icmp, ip_active, busy, timeout_err, length_err;
    logic [7:0]  ip_data;
    logic [15:0] ip_length;
    logic [31:0] ip_destination_ip;

    int total = 0;
    int bad   = 0;
    int n;
    int ens;
    logic seen;
    logic [7:0] pat [4];

    ip_tx_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .udp_req(udp_req), .udp_length(udp_length), .udp_dest_ip(udp_dest_ip),
        .udp_tx_enable(udp_tx_enable), .udp_data(udp_data), .udp_grant(udp_grant),
        .icmp_req(icmp_req), .icmp_length(icmp_length), .icmp_dest_ip(icmp_dest_ip),
        .icmp_tx_enable(icmp_tx_enable), .icmp_data(icmp_data), .icmp_grant(icmp_grant),
        .ip_tx_enable(ip_tx_enable), .ip_data(ip_data), .ip_is_icmp(ip_is_icmp),
        .ip_length(ip_length), .ip_destination_ip(ip_destination_ip), .ip_active(ip_active),
        .busy(busy), .timeout_err(timeout_err), .length_err(length_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC; pat[3] = 8'hDD;
        reset = 1'b0;
        udp_req = 1'b0; udp_length = 16'd0; udp_dest_ip = 32'd0; udp_tx_enable = 1'b0; udp_data = 8'd0;
        icmp_req = 1'b0; icmp_length = 16'd0; icmp_dest_ip = 32'd0; icmp_tx_enable = 1'b0; icmp_data = 8'd0;
        ip_active = 1'b0;
        tick(); tick();
        chk("rst_udp_grant",  32'(udp_grant), 32'd0);
        chk("rst_icmp_grant", 32'(icmp_grant), 32'd0);
        chk("rst_ip_tx_en",   32'(ip_tx_enable), 32'd0);
        chk("rst_is_icmp",    32'(ip_is_icmp), 32'd0);
        chk("rst_length",     32'(ip_length), 32'd0);
        chk("rst_dest",       ip_destination_ip, 32'd0);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_errs",       32'({timeout_err, length_err}), 32'd0);
        reset = 1'b1;
        tick();

        // UDP only, 4-byte burst
        udp_length = 16'd4; udp_dest_ip = 32'hC0A80164; udp_req = 1'b1;
        #1;
        chk("u1_grant_pre", 32'(udp_grant), 32'd0);
        tick();
        chk("u1_grant",   32'(udp_grant), 32'd1);
        chk("u1_length",  32'(ip_length), 32'd4);
        chk("u1_is_icmp", 32'(ip_is_icmp), 32'd0);
        chk("u1_dest",    ip_destination_ip, 32'hC0A80164);
        chk("u1_busy",    32'(busy), 32'd1);
        udp_req = 1'b0; udp_tx_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            udp_data = pat[i];
            #1;
            chk("u1_tx_en", 32'(ip_tx_enable), 32'd1);
            chk("u1_data",  32'(ip_data), 32'(pat[i]));
            ip_active = 1'b1;
            tick();
        end
        udp_tx_enable = 1'b0;
        #1;
        chk("u1_tx_en_end", 32'(ip_tx_enable), 32'd0);
        tick();
        chk("u1_grant_drop", 32'(udp_grant), 32'd0);
        chk("u1_len_err",    32'(length_err), 32'd0);
        udp_length = 16'd10; udp_req = 1'b1;
        tick(); tick();
        chk("u1_drain_busy",  32'(busy), 32'd1);
        chk("u1_drain_grant", 32'(udp_grant), 32'd0);
        ip_active = 1'b0;
        n = 0;
        while (!udp_grant && n < 100) begin tick(); n++; end
        chk("u1_gap_clocks", 32'(n), 32'(GAP + 2));
        chk("u2_length",     32'(ip_length), 32'd10);

        // UDP length 10, 7-byte burst, ICMP driving its bus meanwhile
        udp_req = 1'b0;
        icmp_req = 1'b1; icmp_length = 16'd20; icmp_dest_ip = 32'h0A000001;
        icmp_tx_enable = 1'b1; icmp_data = 8'h55;
        udp_tx_enable = 1'b1; ens = 0;
        for (int i = 0; i < 7; i++) begin
            udp_data = 8'h10 + 8'(i);
            #1;
            chk("u2_data",       32'(ip_data), 32'(8'h10 + 8'(i)));
            chk("u2_icmp_grant", 32'(icmp_grant), 32'd0);
            if (ip_tx_enable) ens++;
            ip_active = 1'b1;
            tick();
        end
        udp_tx_enable = 1'b0;
        #1;
        if (ip_tx_enable) ens++;
        chk("u2_tx_en_cycles", 32'(ens), 32'd7);
        tick();
        chk("u2_len_err",   32'(length_err), 32'd1);
        chk("u2_grant_off", 32'(udp_grant), 32'd0);
        icmp_tx_enable = 1'b0;
        tick();
        chk("u2_len_err_pulse", 32'(length_err), 32'd0);
        ip_active = 1'b0;
        n = 0;
        while (!icmp_grant && n < 100) begin tick(); n++; end
        chk("i1_gap_clocks", 32'(n), 32'(GAP + 2));
        chk("i1_is_icmp",    32'(ip_is_icmp), 32'd1);
        chk("i1_length",     32'(ip_length), 32'd20);
        chk("i1_dest",       ip_destination_ip, 32'h0A000001);

        // ICMP never starts: timeout
        icmp_req = 1'b0; seen = 1'b0; n = 0;
        while (!timeout_err && n < 400) begin
            tick(); n++;
            if (ip_tx_enable) seen = 1'b1;
        end
        chk("to_clocks",     32'(n), 32'(TMO));
        chk("to_icmp_grant", 32'(icmp_grant), 32'd0);
        chk("to_tx_en_seen", 32'(seen), 32'd0);
        chk("to_busy_gap",   32'(busy), 32'd1);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'd0);
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("to_back_idle", 32'(busy), 32'd0);

        // Asynchronous reset at byte 3 of an 8-byte UDP burst
        udp_length = 16'd8; udp_req = 1'b1;
        tick();
        chk("r_udp_grant", 32'(udp_grant), 32'd1);
        udp_req = 1'b0; icmp_req = 1'b1;
        udp_tx_enable = 1'b1; ip_active = 1'b1;
        udp_data = 8'd1; tick();
        udp_data = 8'd2; tick();
        udp_data = 8'd3;
        #2;
        chk("r_tx_en_pre", 32'(ip_tx_enable), 32'd1);
        reset = 1'b0;
        #1;
        chk("r_udp_grant0",  32'(udp_grant), 32'd0);
        chk("r_icmp_grant0", 32'(icmp_grant), 32'd0);
        chk("r_tx_en0",      32'(ip_tx_enable), 32'd0);
        chk("r_length0",     32'(ip_length), 32'd0);
        chk("r_dest0",       ip_destination_ip, 32'd0);
        chk("r_is_icmp0",    32'(ip_is_icmp), 32'd0);
        chk("r_busy0",       32'(busy), 32'd0);
        udp_tx_enable = 1'b0; ip_active = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("r_icmp_grant", 32'(icmp_grant), 32'd1);
        chk("r_udp_idle",   32'(udp_grant), 32'd0);
        chk("r_is_icmp",    32'(ip_is_icmp), 32'd1);
        chk("r_length",     32'(ip_length), 32'd20);
        icmp_req = 1'b0;

        // Both requesting out of reset: U, I, U, I; ICMP length 0 with a one-byte burst
        reset = 1'b0;
        #1;
        udp_req = 1'b1; icmp_req = 1'b1; udp_length = 16'd1; icmp_length = 16'd0;
        tick();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            n = 0;
            while (!(udp_grant || icmp_grant) && n < 100) begin tick(); n++; end
            chk("rr_wait_ok", 32'(n < 100), 32'd1);
            chk("rr_udp",     32'(udp_grant), 32'(p % 2 == 0));
            chk("rr_icmp",    32'(icmp_grant), 32'(p % 2 == 1));
            if (icmp_grant) icmp_tx_enable = 1'b1;
            else            udp_tx_enable = 1'b1;
            ip_active = 1'b1;
            tick();
            udp_tx_enable = 1'b0; icmp_tx_enable = 1'b0;
            tick();
            chk("rr_len_err", 32'(length_err), 32'(p % 2 == 1));
            ip_active = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares the single IP header transmitter between two payload sources: the UDP sender and the ICMP echo responder.
- Arbitrates requests round-robin and latches the winner's length and destination IP for the whole packet.
- Muxes the winner's tx_enable/data straight into the IP transmitter, waits for that transmitter's active to drop, then enforces an inter-packet gap.
- Sits between the UDP/ICMP senders and the IP header transmitter.

Parameters:
- GAP_CYCLES, 12: idle clocks after ip_active falls before the next grant (≥1).
- START_TIMEOUT, 255: clocks the granted source may hold grant without asserting tx_enable before the grant is revoked.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- udp_req  in  1  UDP source requests a slot (level)
- udp_length  in  16  UDP payload length in bytes, valid with udp_req
- udp_dest_ip  in  32  UDP destination IP, valid with udp_req
- udp_tx_enable  in  1  UDP payload byte valid, contiguous burst
- udp_data  in  8  UDP payload byte
- udp_grant  out  1  UDP owns the transmitter
- icmp_req, icmp_length, icmp_dest_ip, icmp_tx_enable, icmp_data, icmp_grant: same as the udp_ ports, for ICMP
- ip_tx_enable  out  1  to IP transmitter tx_enable
- ip_data  out  8  to IP transmitter data_in
- ip_is_icmp  out  1  to IP transmitter is_icmp
- ip_length  out  16  to IP transmitter length
- ip_destination_ip  out  32  to IP transmitter destination_ip
- ip_active  in  1  IP transmitter active
- busy  out  1  state != IDLE
- timeout_err  out  1  one-clock pulse, grant revoked by timeout
- length_err  out  1  one-clock pulse, burst byte count != latched length

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all grants 0; ip_tx_enable 0; ip_is_icmp 0; ip_length 0; ip_destination_ip 0; error pulses 0; last_served=ICMP, so UDP wins the first tie; timers 0.
- States: IDLE, GRANT, SEND, DRAIN, GAP.
- IDLE:
  - If any req is set and ip_active=0, pick the winner: sole requester, or on a tie the source not in last_served.
  - Latch length, dest_ip and is_icmp (1 for ICMP).
  - Set that grant and last_served; go to GRANT.
  - If ip_active=1, stay in IDLE.
- GRANT:
  - Grant held high.
  - Winner tx_enable=1 → SEND. That first byte passes through the same cycle, and byte_cnt loads 1.
  - Timer reaches START_TIMEOUT → drop grant, pulse timeout_err, go to GAP. last_served still updates.
- SEND:
  - Grant held high. byte_cnt increments on each tx_enable=1 clock (16-bit, saturating at FFFF).
  - First clock with tx_enable=0 → drop grant. If byte_cnt != latched length, pulse length_err. Go to DRAIN.
  - The packet is not truncated on length_err.
- DRAIN: wait for ip_active=0, then load the gap counter and go to GAP.
- GAP: count GAP_CYCLES clocks, then go to IDLE.
- Datapath is zero-latency combinational:
  - ip_tx_enable = winner tx_enable AND (state is GRANT or SEND).
  - ip_data = winner data.
  - ip_is_icmp, ip_length and ip_destination_ip come from the latched registers and stay stable from grant until the next grant.
  - The non-granted source's tx_enable/data are ignored in every state.
- Grant is a level signal. A source must deassert req within one clock of its grant falling, or it re-requests; it is still subject to round-robin.
- req dropping while in GRANT: the slot is kept until the timeout.
- Zero latched length: a one-byte burst raises length_err.
- A new request arriving in DRAIN or GAP waits; no grant is given while ip_active=1.
- Reset mid-packet: the FSM returns to IDLE immediately and ip_tx_enable falls asynchronously. The downstream transmitter purges its header on its own.

Test Plan:
- Only UDP requests, length=4, dest=C0A80164, 4-byte burst AA BB CC DD:
  - udp_grant rises 1 clock after req; ip_length=4; ip_is_icmp=0.
  - ip_data carries AA..DD on the same cycles.
  - No errors; the next grant is not before ip_active fall + 12 clocks.
- udp_req and icmp_req both asserted out of reset:
  - UDP is served first, ICMP second.
  - With both still requesting, the order alternates U, I, U, I over 4 packets.
- ICMP granted, never asserts tx_enable:
  - timeout_err pulses 255 clocks after grant; icmp_grant falls.
  - State goes to GAP; ip_tx_enable stays 0 throughout.
- UDP length=10 but sends a 7-byte burst: length_err pulses 1 clock after the burst ends; ip_tx_enable is high for exactly 7 clocks.
- During a UDP burst, ICMP drives icmp_tx_enable=1 and icmp_data=55: ip_data never shows 55; icmp_grant stays 0 until UDP's gap expires.
- Reset driven low mid-burst (byte 3 of 8): all outputs return to reset values with no clock edge; after release, a pending ICMP req is granted normally.
